int_mul_iter: RTL and testbench
===============================

# int_mul_iter

Parametrised, multi-cycle integer multiplier for the posit MAC datapath. It replaces the single-cycle N×N product with an N×M shift-add engine that retires K multiplier bits per clock. The engine has valid/ready handshakes on both sides and an optional signed mode. It sits between the posit decode stage, which supplies the fractions including the hidden bit, and the accumulator/normaliser.

## Interface
Parameters:
- N, 5, width of multiplicand x
- M, 5, width of multiplier y
- K, 1, multiplier bits retired per cycle; legal range 1..M
- ITER, ceil(M/K), derived localparam; never overridden

Ports:
- clk  in  1  rising-edge clock (one clock domain)
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  engine can accept operands
- x  in  N  multiplicand
- y  in  M  multiplier
- is_signed  in  1  treat x/y as two's complement; present only with INT_MUL_SIGNED_EN
- out_valid  out  1  r holds a completed product
- out_ready  in  1  consumer takes r
- r  out  N+M  product
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. A transfer occurs on in_valid&&in_ready. On transfer:
  - latch x and y
  - zero-extend y (sign-extend in signed mode) to ITER*K bits
  - clear acc (N+M bits) and cnt
  - go to BUSY.
- BUSY: each cycle acc += x_ext * y_slice[cnt] << (K*cnt), then cnt++.
  - x_ext is x extended to N+M bits.
  - In signed mode the top slice carries negative weight (it is subtracted).
  - All arithmetic is truncated modulo 2^(N+M).
  - After the ITER-th BUSY cycle, load r with the final acc and go to DONE.
- DONE: out_valid=1. r stays stable until out_valid&&out_ready.
  - If in_valid is also high in that cycle, accept the new operands and go directly to BUSY (back-to-back).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready and is the only combinational in→out path.
- r is held from one DONE load to the next. It is meaningful only while out_valid=1.
- Operand changes while in_ready=0 are ignored.

## Timing
- Reset values: in_ready=0 while rst_n low, then 1; out_valid=0; r=0; busy=0; state=IDLE.
- Latency: operands accepted at edge e produce out_valid=1 after edge e+ITER.
- Throughput with out_ready held high: one product every ITER+1 cycles.
- rst_n asserted in any state: immediately go to IDLE and clear out_valid and r. The in-flight operation is discarded with no partial output. Release is synchronous to clk via the standard reset-release flop.
- Boundary cases:
  - K=M: ITER=1, latency 1.
  - M not a multiple of K: pad bits do not change the result.
  - Operand 0 still takes the full ITER cycles; there is no early exit.

## Configuration
- INT_MUL_SIGNED_EN defined:
  - the is_signed port exists
  - is_signed is sampled with the operands at transfer and held for the whole operation
  - is_signed=1 gives the two's-complement product
- Not defined: no is_signed port; unsigned only; the top-slice subtract logic is removed.

## Structure
- int_mul_pkg holds:
  - the state enum (IDLE/BUSY/DONE)
  - the ITER computation function
  - the slice-select helper
- Sub-module int_mul_pp_row: combinational x_ext × K-bit slice partial-product row, with a neg input for the top signed slice. It is instantiated once.

## Test plan
- N=M=5, K=1: x=31, y=31, out_ready=1 → r=961 (10'h3C1), out_valid exactly 5 cycles after accept, then in_ready=1.
- N=M=5, K=2: x=13, y=22 → r=286, latency 3. Repeat with K=5: same r, latency 1.
- Backpressure: complete x=3, y=7 with out_ready=0 for 4 cycles → r=21 stable, out_valid held, in_ready=0. Then out_ready=1 with in_valid=1 (x=2, y=2) → back-to-back accept and r=4 on the next DONE.
- Signed (macro on), N=M=5, K=1:
  - x=5'b10000, y=5'b10000 → r=256
  - x=7, y=5'b11111 → r=10'h3F9 (−7)
  - same operands with is_signed=0 → r=217
- Reset mid-BUSY at cnt=2 → out_valid=0, r=0, busy=0 immediately. The next operation x=5, y=6 gives r=30.
- Random sweep of 1000 operand pairs over K∈{1,2,3,5} against a reference model, with random out_ready stalls; every product is matched in order with no loss or duplication.

Source files
------------

// File: rtl/int_mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package int_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_iter(input int unsigned m, input int unsigned k);
    return (m + k - 1) / k;
  endfunction

  // LSB position of multiplier slice idx; also the shift of its partial-product row.
  function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned idx);
    return k * idx;
  endfunction

endpackage

// File: rtl/int_mul_pp_row.sv
// One partial-product row: x_ext times a K-bit multiplier slice, truncated to W bits.
module int_mul_pp_row #(
  parameter int W = 10,
  parameter int K = 1
) (
  input  logic [W-1:0] x_ext,
  input  logic [K-1:0] slice,
  input  logic         neg,
  output logic [W-1:0] pp
);

  logic [W-1:0] slice_ext;

  // neg marks the top slice of a signed multiplier: its MSB weighs -2^(K-1),
  // so the slice is taken as a K-bit two's-complement value.
  always_comb begin
    slice_ext = W'(slice);
    if (neg) slice_ext = W'($signed(slice));
  end

  assign pp = x_ext * slice_ext;

endmodule

// File: rtl/int_mul_iter.sv
// Multi-cycle N x M shift-add multiplier retiring K multiplier bits per clock.
// Define INT_MUL_SIGNED_EN to add the is_signed port and two's-complement mode.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | accumulating one partial-product row per cycle
// DONE  | r valid, waiting for out_ready
module int_mul_iter
  import int_mul_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 5,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [M-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] r,
  output logic           busy
`ifdef INT_MUL_SIGNED_EN
  ,
  input  logic           is_signed
`endif
);

  localparam int unsigned ITER = calc_iter(M, K);
  localparam int W  = N + M;
  localparam int YW = ITER * K;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t        state;
  logic          rel_q;
  logic [W-1:0]  x_q;
  logic [YW-1:0] y_q;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          take;
  logic          last;
  logic          sg_in;
  logic          neg;
  logic [W-1:0]  x_ext_in;
  logic [YW-1:0] y_ext_in;
  logic [K-1:0]  slice;
  logic [W-1:0]  pp;
  logic [W-1:0]  acc_next;

`ifdef INT_MUL_SIGNED_EN
  logic sg_q;

  assign sg_in = is_signed;
  assign neg   = sg_q && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sg_q <= 1'b0;
    else if (take) sg_q <= is_signed;
  end
`else
  assign sg_in = 1'b0;
  assign neg   = 1'b0;
`endif

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_q <= 1'b0;
    else        rel_q <= 1'b1;
  end

  assign in_ready = rel_q && ((state == IDLE) || ((state == DONE) && out_ready));
  assign take     = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign last     = (cnt == CW'(ITER - 1));

  assign x_ext_in = sg_in ? W'($signed(x))  : W'(x);
  assign y_ext_in = sg_in ? YW'($signed(y)) : YW'(y);

  assign slice    = y_q[slice_lsb(K, 32'(cnt)) +: K];
  assign acc_next = acc + (pp << slice_lsb(K, 32'(cnt)));

  int_mul_pp_row #(.W(W), .K(K)) u_pp_row (
    .x_ext (x_q),
    .slice (slice),
    .neg   (neg),
    .pp    (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      r         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) state <= BUSY;
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            r         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= take ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase
      // Operand capture is shared by IDLE and the back-to-back path out of DONE.
      if (take) begin
        x_q <= x_ext_in;
        y_q <= y_ext_in;
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_int_mul_iter.sv
// Directed and randomised checks of int_mul_iter for K = 1, 2, 3, 5 (N = M = 5).
module tb_int_mul_iter;

  logic       clk;
  logic       rst_n;
  logic       in_valid_a  [4];
  logic       in_ready_a  [4];
  logic       out_valid_a [4];
  logic       out_ready_a [4];
  logic       busy_a      [4];
  logic       sg_a        [4];
  logic [4:0] x_a         [4];
  logic [4:0] y_a         [4];
  logic [9:0] r_a         [4];

  int checks   = 0;
  int failures = 0;
  int iter_tab [4] = '{5, 3, 2, 1};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    int_mul_iter #(
      .N(5), .M(5),
      .K((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .x         (x_a[g]),
      .y         (y_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .r         (r_a[g]),
      .busy      (busy_a[g])
`ifdef INT_MUL_SIGNED_EN
      ,
      .is_signed (sg_a[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_mul(input logic [4:0] a, input logic [4:0] b, input logic sg);
    logic [9:0] ae, be;
    ae = sg ? {{5{a[4]}}, a} : {5'b0, a};
    be = sg ? {{5{b[4]}}, b} : {5'b0, b};
    return ae * be;
  endfunction

  // Offers one operand pair, then waits (bounded) for out_valid and checks latency and product.
  task automatic do_op(input int i, input logic [4:0] xv, input logic [4:0] yv,
                       input logic sg, input logic [9:0] exp, input string tag);
    int lat;
    @(negedge clk);
    x_a[i] = xv; y_a[i] = yv; sg_a[i] = sg; in_valid_a[i] = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready_a[i]), 32'd1);
    @(posedge clk);
    #1 in_valid_a[i] = 1'b0;
    lat = 0;
    while (!out_valid_a[i] && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(iter_tab[i]));
    chk({tag, "_r"}, 32'(r_a[i]), 32'(exp));
  endtask

  initial begin
    int s;
    logic [4:0] xv, yv;
    logic sg;

    for (int i = 0; i < 4; i++) begin
      in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b1; sg_a[i] = 1'b0;
      x_a[i] = '0; y_a[i] = '0;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready_a[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    chk("rst_r", 32'(r_a[0]), 32'd0);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 32'(in_ready_a[0]), 32'd0);
    @(posedge clk);
    #1 chk("rel_in_ready_high", 32'(in_ready_a[0]), 32'd1);

    // K=1 full-scale product, then handshake returns to idle
    do_op(0, 5'd31, 5'd31, 1'b0, 10'd961, "k1_31x31");
    @(posedge clk);
    #1;
    chk("k1_after_in_ready", 32'(in_ready_a[0]), 32'd1);
    chk("k1_after_out_valid", 32'(out_valid_a[0]), 32'd0);
    chk("k1_after_busy", 32'(busy_a[0]), 32'd0);

    do_op(1, 5'd13, 5'd22, 1'b0, 10'd286, "k2_13x22");
    do_op(2, 5'd13, 5'd22, 1'b0, 10'd286, "k3_13x22");
    do_op(3, 5'd13, 5'd22, 1'b0, 10'd286, "k5_13x22");
    do_op(0, 5'd0, 5'd19, 1'b0, 10'd0, "k1_zero");
    do_op(0, 5'd21, 5'd1, 1'b0, 10'd21, "k1_b2b");
    @(posedge clk);
    #1;

    // backpressure then back-to-back accept out of DONE
    out_ready_a[0] = 1'b0;
    do_op(0, 5'd3, 5'd7, 1'b0, 10'd21, "bp_3x7");
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_r", 32'(r_a[0]), 32'd21);
      chk("bp_hold_valid", 32'(out_valid_a[0]), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready_a[0]), 32'd0);
    end
    @(negedge clk);
    out_ready_a[0] = 1'b1; in_valid_a[0] = 1'b1; x_a[0] = 5'd2; y_a[0] = 5'd2;
    #1 chk("bp_comb_in_ready", 32'(in_ready_a[0]), 32'd1);
    @(posedge clk);
    #1 in_valid_a[0] = 1'b0;
    chk("bp_b2b_out_valid", 32'(out_valid_a[0]), 32'd0);
    chk("bp_b2b_busy", 32'(busy_a[0]), 32'd1);
    s = 0;
    while (!out_valid_a[0] && s < 40) begin
      @(posedge clk);
      #1 s++;
    end
    chk("bp_b2b_lat", 32'(s), 32'd5);
    chk("bp_b2b_r", 32'(r_a[0]), 32'd4);

`ifdef INT_MUL_SIGNED_EN
    do_op(0, 5'b10000, 5'b10000, 1'b1, 10'd256, "s_m16xm16");
    do_op(0, 5'd7, 5'b11111, 1'b1, 10'h3F9, "s_7xm1");
    do_op(0, 5'd7, 5'b11111, 1'b0, 10'd217, "u_7x31");
    do_op(2, 5'd7, 5'b11111, 1'b1, 10'h3F9, "s_k3_7xm1");
    do_op(1, 5'b11101, 5'd6, 1'b1, 10'h3EE, "s_k2_m3x6");
`endif

    // reset while BUSY at cnt=2
    @(negedge clk);
    x_a[0] = 5'd31; y_a[0] = 5'd31; in_valid_a[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_a[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("mid_busy_before", 32'(busy_a[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    chk("mid_rst_r", 32'(r_a[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_a[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_a[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(0, 5'd5, 5'd6, 1'b0, 10'd30, "post_rst_5x6");
    @(posedge clk);
    #1;

    // random sweep with output stalls, 250 operations per K
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 250; n++) begin
        xv = 5'($urandom_range(0, 31));
        yv = 5'($urandom_range(0, 31));
        sg = 1'b0;
`ifdef INT_MUL_SIGNED_EN
        sg = 1'($urandom_range(0, 1));
`endif
        s = $urandom_range(0, 3);
        out_ready_a[i] = 1'b0;
        do_op(i, xv, yv, sg, ref_mul(xv, yv, sg), "rnd");
        for (int j = 0; j < s; j++) begin
          @(posedge clk);
          #1 chk("rnd_stall_r", 32'(r_a[i]), 32'(ref_mul(xv, yv, sg)));
        end
        @(negedge clk);
        out_ready_a[i] = 1'b1;
        @(posedge clk);
        #1 chk("rnd_taken", 32'(out_valid_a[i]), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
